// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES-128 definitions: S-box, GF(2^8) helpers, round transforms and FSM states.
// Blocks are held as block_t: element 15 is byte 0 ([127:120]), element 0 is byte 15 ([7:0]).
package aes_cipher_iter_pkg;

  localparam int unsigned NR_AES128 = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef logic [15:0][7:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // FIPS byte number n -> block_t element index.
  function automatic logic [3:0] bidx(input int unsigned n);
    return 4'(15 - n);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic block_t sub_bytes(input block_t s);
    block_t o;
    for (int unsigned i = 0; i < 16; i++) o[4'(i)] = sbox(s[4'(i)]);
    return o;
  endfunction

  // Row r of every column rotated left by r.
  function automatic block_t shift_rows(input block_t s);
    block_t o;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[bidx(4 * c + r)] = s[bidx(4 * ((c + r) % 4) + r)];
    return o;
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[bidx(4 * c)];
      a1 = s[bidx(4 * c + 1)];
      a2 = s[bidx(4 * c + 2)];
      a3 = s[bidx(4 * c + 3)];
      o[bidx(4 * c)]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[bidx(4 * c + 1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[bidx(4 * c + 2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[bidx(4 * c + 3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_cipher_iter_key_step.sv
// AES-128 key schedule step: current round key + rcon -> next round key.
// Ports: key (current round key), rcon (round constant), next_key_c (combinational next key).
module aes_cipher_iter_key_step
  import aes_cipher_iter_pkg::*;
#(
  parameter int unsigned RCON_W = 8
) (
  input  logic [127:0]        key,
  input  logic [RCON_W-1:0]   rcon,
  output logic [127:0]        next_key_c
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, tmp_w;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;

  // RotWord, SubWord, then Rcon into the top byte.
  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
  assign tmp_w = sub_w ^ (32'(rcon) << (32 - RCON_W));

  // Word chain.
  assign n0 = w0 ^ tmp_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_c = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption engine, one round per clock, key expanded on the fly.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_valid/o_ready/i_data/i_key input
// handshake with plaintext and key; o_valid/i_ready/o_data output handshake with ciphertext;
// o_busy high while rounds are running.
module aes_cipher_iter
  import aes_cipher_iter_pkg::*;
#(
  parameter int unsigned NR     = 10,
  parameter int unsigned RCON_W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  input  logic [127:0] i_key,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data,
  output logic         o_busy
);

  localparam int unsigned RND_W = $clog2(NR + 1);

  // Only the AES-128 configuration is supported.
  if (NR != NR_AES128 || RCON_W != 8) begin : g_bad_cfg
    $fatal(1, "aes_cipher_iter: NR must be 10 and RCON_W must be 8");
  end

  state_e             state;
  block_t             state_reg;
  logic [127:0]       key_reg;
  logic [RND_W-1:0]   rnd;
  logic [RCON_W-1:0]  rcon;

  logic [127:0]       nk_c;
  block_t             sb_c, sr_c, mc_c, round_c;
  logic               last_c;

  aes_cipher_iter_key_step #(.RCON_W(RCON_W)) u_key_step (
    .key        (key_reg),
    .rcon       (rcon),
    .next_key_c (nk_c)
  );

  // Round datapath; the final round has no MixColumns.
  assign sb_c    = sub_bytes(state_reg);
  assign sr_c    = shift_rows(sb_c);
  assign mc_c    = mix_columns(sr_c);
  assign last_c  = (rnd == RND_W'(NR));
  assign round_c = (last_c ? sr_c : mc_c) ^ nk_c;

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      rnd       <= '0;
      rcon      <= RCON_W'(RCON_INIT);
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_ready   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            state_reg <= i_data ^ i_key;
            key_reg   <= i_key;
            rnd       <= RND_W'(1);
            rcon      <= RCON_W'(RCON_INIT);
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
            state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          key_reg   <= nk_c;
          state_reg <= round_c;
          rcon      <= RCON_W'(xtime(8'(rcon)));
          rnd       <= rnd + RND_W'(1);
          if (last_c) begin
            o_data  <= round_c;
            o_valid <= 1'b1;
            o_busy  <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Hold the result; no re-accept on the consuming edge.
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
